// File: rtl/conv_mac_unit.sv
// rtl/conv_mac_unit.sv - sequential 8x8 multiply-accumulate over a KSIZE x KSIZE sub-window
module conv_mac_unit #(
    parameter int KSIZE = 5,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [199:0]     matrix_A,
    input  logic [199:0]     matrix_B,
    output logic [ACC_W-1:0] matrix_ula,
    output logic             we_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST = 3'(KSIZE - 1);

    state_t           state_q, state_d;
    logic [199:0]     a_q, a_d;
    logic [199:0]     b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [ACC_W-1:0] ula_q, ula_d;
    logic             we_q, we_d;

    logic [4:0]        elem_idx;
    logic [7:0]        bit_base;
    logic [7:0]        a_elem;
    logic [7:0]        b_elem;
    logic signed [16:0] a_ext;
    logic signed [16:0] b_ext;
    logic signed [16:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  post_val;

    // Pick the current window element and form its sign-extended 9x8 signed product
    always_comb begin
        elem_idx = 5'(row_q) * 5'd5 + 5'(col_q);
        bit_base = {elem_idx, 3'b000};
        a_elem   = a_q[bit_base +: 8];
        b_elem   = b_q[bit_base +: 8];
        a_ext    = {9'b0, a_elem};
        b_ext    = {{9{b_elem[7]}}, b_elem};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-17){prod[16]}}, prod};
    end

    // Post-processing of the finished sum according to the mode captured at start
    always_comb begin
        post_val = acc_q;
        case (mode_q)
            2'd1: begin
                if (acc_q[ACC_W-1]) begin
                    post_val = '0;
                end else if (acc_q > ACC_W'(255)) begin
                    post_val = ACC_W'(255);
                end
            end
            2'd2: begin
                if (acc_q[ACC_W-1]) begin
                    post_val = '0 - acc_q;
                end
            end
            default: post_val = acc_q;
        endcase
    end

    // Next-state and datapath updates for the IDLE -> MAC -> POST -> DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        row_d   = row_q;
        col_d   = col_q;
        ula_d   = ula_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = matrix_A;
                    b_d     = matrix_B;
                    mode_d  = mode;
                    acc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (col_q == LAST) begin
                    col_d = '0;
                    row_d = row_q + 3'd1;
                    if (row_q == LAST) begin
                        state_d = S_POST;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_POST: begin
                ula_d   = post_val;
                we_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any convolution in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ula_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ula_q   <= ula_d;
            we_q    <= we_d;
        end
    end

    assign matrix_ula = ula_q;
    assign we_out     = we_q;
    assign busy       = (state_q == S_MAC) || (state_q == S_POST);

endmodule

// File: tb/tb_conv_mac_unit.sv
// tb/tb_conv_mac_unit.sv - self-checking bench for conv_mac_unit (KSIZE 5 and 3 instances)
module tb_conv_mac_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start5;
    logic         start3;
    logic [1:0]   mode;
    logic [199:0] mat_a;
    logic [199:0] mat_b;
    logic [23:0]  ula5, ula3;
    logic         we5, we3, busy5, busy3;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    conv_mac_unit #(.KSIZE(5), .ACC_W(24)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .mode(mode),
        .matrix_A(mat_a), .matrix_B(mat_b),
        .matrix_ula(ula5), .we_out(we5), .busy(busy5)
    );

    conv_mac_unit #(.KSIZE(3), .ACC_W(24)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .mode(mode),
        .matrix_A(mat_a), .matrix_B(mat_b),
        .matrix_ula(ula3), .we_out(we3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [199:0] rand_mat();
        logic [199:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    // Reference: plain integer dot product over the k x k corner, then the mode rule
    function automatic logic [23:0] model(input int k, input logic [1:0] m,
                                          input logic [199:0] a, input logic [199:0] b);
        int s;
        int av;
        int bv;
        logic [7:0] ae;
        logic signed [7:0] be;
        s = 0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                ae = a[(r*5+c)*8 +: 8];
                be = b[(r*5+c)*8 +: 8];
                av = ae;
                bv = be;
                s += av * bv;
            end
        end
        if (m == 2'd1) begin
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
        end else if (m == 2'd2) begin
            if (s < 0) s = -s;
        end
        return 24'(s);
    endfunction

    task automatic run_conv(input int k, input string tag, input logic [23:0] exp);
        int lat;
        logic [199:0] sa, sb;
        logic [1:0] sm;
        logic we_sel;
        sa = mat_a; sb = mat_b; sm = mode;
        if (k == 5) start5 = 1'b1; else start3 = 1'b1;
        step();
        start5 = 1'b0;
        start3 = 1'b0;
        mat_a = ~mat_a;
        mat_b = rand_mat();
        mode  = ~mode;
        check({tag, "_busy_mac"}, (k == 5) ? busy5 : busy3, 1);
        lat = 0;
        we_sel = 1'b0;
        while (!we_sel && lat < 200) begin
            step();
            lat++;
            we_sel = (k == 5) ? we5 : we3;
        end
        check({tag, "_latency"}, lat, k * k + 1);
        check({tag, "_result"}, (k == 5) ? ula5 : ula3, exp);
        check({tag, "_busy_done"}, (k == 5) ? busy5 : busy3, 0);
        step();
        check({tag, "_we_single"}, (k == 5) ? we5 : we3, 0);
        step();
        check({tag, "_hold"}, (k == 5) ? ula5 : ula3, exp);
        mat_a = sa; mat_b = sb; mode = sm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rises[$];
        int cyc;
        int viol;
        int we_cnt;
        logic prev_we;
        logic [23:0] exp;

        reset  = 1'b1;
        start5 = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        mat_a  = '0;
        mat_b  = '0;
        step();
        step();
        check("reset_ula5", ula5, 0);
        check("reset_we5", we5, 0);
        check("reset_busy5", busy5, 0);
        check("reset_ula3", ula3, 0);
        reset = 1'b0;
        step();

        // All ones, raw sum
        mat_a = fill(8'd1); mat_b = fill(8'd1); mode = 2'd0;
        run_conv(5, "t1", 24'd25);

        // Worst-case magnitude in three modes
        mat_a = fill(8'd255); mat_b = fill(8'h80);
        mode = 2'd0; run_conv(5, "t2_raw", 24'hF38C80);
        mode = 2'd2; run_conv(5, "t2_abs", 24'h0C7380);
        mode = 2'd1; run_conv(5, "t2_clamp", 24'd0);
        mode = 2'd3; run_conv(5, "t2_mode3", 24'hF38C80);

        // Identity kernel, then a clamped doubled centre
        mat_a = rand_mat(); mat_a[12*8 +: 8] = 8'd200;
        mat_b = '0; mat_b[12*8 +: 8] = 8'd1; mode = 2'd1;
        run_conv(5, "t3_ident", 24'd200);
        mat_b[12*8 +: 8] = 8'd2;
        run_conv(5, "t3_clamp", 24'd255);

        // 3x3 window must ignore everything outside rows/cols 0..2
        mat_a = fill(8'd10); mat_b = fill(8'h7F);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mat_b[(r*5+c)*8 +: 8] = 8'd1;
        mode = 2'd0;
        run_conv(3, "t4_k3", 24'd90);

        // Randomized runs against the reference model
        for (int it = 0; it < 6; it++) begin
            mat_a = rand_mat(); mat_b = rand_mat(); mode = 2'($urandom);
            run_conv(5, $sformatf("rnd5_%0d", it), model(5, mode, mat_a, mat_b));
            run_conv(3, $sformatf("rnd3_%0d", it), model(3, mode, mat_a, mat_b));
        end

        // Start held high: fixed period, no overlapping or back-to-back strobes
        mat_a = rand_mat(); mat_b = rand_mat(); mode = 2'd2;
        exp = model(5, mode, mat_a, mat_b);
        viol = 0; prev_we = 1'b0;
        start5 = 1'b1;
        for (cyc = 0; cyc < 100; cyc++) begin
            step();
            if (we5 && (busy5 || prev_we)) viol++;
            if (we5 && !prev_we) begin
                rises.push_back(cyc);
                check("t5_result", ula5, exp);
            end
            prev_we = we5;
        end
        start5 = 1'b0;
        check("t5_violations", viol, 0);
        check("t5_pulse_count", (rises.size() >= 3) ? 1 : 0, 1);
        for (int i = 1; i < rises.size(); i++)
            check("t5_period", rises[i] - rises[i-1], 28);
        cyc = 0;
        while ((busy5 || we5) && cyc < 40) begin
            step();
            cyc++;
        end
        step();

        // Reset five cycles into MAC, then a clean rerun
        mat_a = fill(8'd1); mat_b = fill(8'd1); mode = 2'd0;
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        repeat (5) step();
        check("t6_busy_before", busy5, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_ula5", ula5, 0);
        check("t6_we5", we5, 0);
        check("t6_busy5", busy5, 0);
        check("t6_ula3", ula3, 0);
        step();
        reset = 1'b0;
        we_cnt = 0;
        repeat (30) begin
            step();
            if (we5) we_cnt++;
        end
        check("t6_no_we", we_cnt, 0);
        run_conv(5, "t6_rerun", 24'd25);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
